// File: rtl/cu_defs.sv
// ============================================================================
//  Package   : cu_defs
//  Purpose   : Shared definitions for the accumulator-CPU control unit:
//              opcodes, sequencer states, control-bit indices, ALU codes
//              and the instruction classes produced by the decoder.
//  Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

package cu_defs;

  // Opcodes as returned by the instruction register (MBR[15:8])
  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_LOAD   = 8'h01;
  localparam logic [7:0] OP_STORE  = 8'h02;
  localparam logic [7:0] OP_ADD    = 8'h03;
  localparam logic [7:0] OP_SUB    = 8'h04;
  localparam logic [7:0] OP_JMPGEZ = 8'h05;
  localparam logic [7:0] OP_JMP    = 8'h06;
  localparam logic [7:0] OP_HALT   = 8'h07;
  localparam logic [7:0] OP_AND    = 8'h08;
  localparam logic [7:0] OP_OR     = 8'h09;
  localparam logic [7:0] OP_NOT    = 8'h0A;
  localparam logic [7:0] OP_SHR    = 8'h0B;
  localparam logic [7:0] OP_MPY    = 8'h0C;
  localparam logic [7:0] OP_CLR    = 8'h0D;

  // Sequencer states
  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_F1   = 4'd1,
    ST_F2   = 4'd2,
    ST_F3   = 4'd3,
    ST_DEC  = 4'd4,
    ST_E1   = 4'd5,
    ST_E2   = 4'd6,
    ST_E3   = 4'd7,
    ST_HALT = 4'd8
  } cu_state_e;

  // Datapath control-bit positions inside ctrl
  localparam int CTRL_C0  = 0;   // MAR <- MBR[7:0]
  localparam int CTRL_C1  = 1;   // PC  <- PC + 1
  localparam int CTRL_C2  = 2;   // MAR <- PC
  localparam int CTRL_C3  = 3;   // MBR <- M[MAR]
  localparam int CTRL_C4  = 4;   // IR  <- MBR[15:8]
  localparam int CTRL_C5  = 5;   // BR  <- MBR
  localparam int CTRL_C6  = 6;   // ACC <- 0
  localparam int CTRL_C7  = 7;   // ACC <- ALU
  localparam int CTRL_C8  = 8;   // MBR <- ACC
  localparam int CTRL_C9  = 9;   // M[MAR] <- MBR
  localparam int CTRL_C10 = 10;  // PC  <- MBR[7:0]

  // ALU function select
  localparam logic [2:0] ALU_PASS_B = 3'd0;
  localparam logic [2:0] ALU_ADD    = 3'd1;
  localparam logic [2:0] ALU_SUB    = 3'd2;
  localparam logic [2:0] ALU_AND    = 3'd3;
  localparam logic [2:0] ALU_OR     = 3'd4;
  localparam logic [2:0] ALU_NOT    = 3'd5;
  localparam logic [2:0] ALU_SHR    = 3'd6;
  localparam logic [2:0] ALU_MPY    = 3'd7;

  // Instruction classes; each class shares one execute sequence
  typedef enum logic [3:0] {
    CLS_NOP   = 4'd0,
    CLS_MEMRD = 4'd1,
    CLS_STORE = 4'd2,
    CLS_JMP   = 4'd3,
    CLS_JMPC  = 4'd4,
    CLS_ALU1  = 4'd5,
    CLS_CLR   = 4'd6,
    CLS_HALT  = 4'd7,
    CLS_MPY   = 4'd8
  } instr_class_e;

endpackage

`default_nettype wire

// File: rtl/cu_sequencer_decode.sv
// ============================================================================
//  Module    : cu_decode
//  Purpose   : Combinational opcode decoder: maps ir_op onto an instruction
//              class and the ALU function that class uses in execute.
//  Options   : CU_MPY_EN - decode 0x0C as MPY (otherwise it is a NOP)
//  Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

module cu_decode
  import cu_defs::*;
(
  input  logic [7:0]   ir_op_i,
  output instr_class_e cls_o,
  output logic [2:0]   alu_op_o
);

  // Opcode lookup; unknown opcodes fall through to NOP with PASS_B
  always_comb begin
    cls_o    = CLS_NOP;
    alu_op_o = ALU_PASS_B;
    case (ir_op_i)
      OP_LOAD:   begin cls_o = CLS_MEMRD; alu_op_o = ALU_PASS_B; end
      OP_ADD:    begin cls_o = CLS_MEMRD; alu_op_o = ALU_ADD;    end
      OP_SUB:    begin cls_o = CLS_MEMRD; alu_op_o = ALU_SUB;    end
      OP_AND:    begin cls_o = CLS_MEMRD; alu_op_o = ALU_AND;    end
      OP_OR:     begin cls_o = CLS_MEMRD; alu_op_o = ALU_OR;     end
      OP_STORE:  cls_o = CLS_STORE;
      OP_JMP:    cls_o = CLS_JMP;
      OP_JMPGEZ: cls_o = CLS_JMPC;
      OP_NOT:    begin cls_o = CLS_ALU1;  alu_op_o = ALU_NOT;    end
      OP_SHR:    begin cls_o = CLS_ALU1;  alu_op_o = ALU_SHR;    end
      OP_CLR:    cls_o = CLS_CLR;
      OP_HALT:   cls_o = CLS_HALT;
`ifdef CU_MPY_EN
      OP_MPY:    begin cls_o = CLS_MPY;   alu_op_o = ALU_MPY;    end
`endif
      default:   begin cls_o = CLS_NOP;   alu_op_o = ALU_PASS_B; end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/cu_sequencer.sv
// ============================================================================
//  Module    : cu_sequencer
//  Purpose   : Hardwired control unit of the accumulator CPU. Sequences
//              fetch (F1-F3), decode (DEC) and execute (E1-E3), drives the
//              datapath enables C0..C10 and the ALU select, and counts
//              fetched instructions.
//  Options   : CU_MPY_EN - adds MPY (0x0C) with an E3 that waits on mul_done
//  Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

module cu_sequencer
  import cu_defs::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       ir_op,
  input  logic             acc_msb,
  input  logic             mul_done,
  output logic [10:0]      ctrl,
  output logic [2:0]       alu_op,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt
);

  cu_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  instr_class_e      dec_cls;
  logic [2:0]        dec_alu;

`ifndef CU_MPY_EN
  // Multiplier handshake has no consumer without the MPY instruction
  logic unused_mul_done;
  assign unused_mul_done = mul_done;
`endif

  cu_decode u_decode (
    .ir_op_i  (ir_op),
    .cls_o    (dec_cls),
    .alu_op_o (dec_alu)
  );

  // State register and retired-instruction counter (bumps on every F3)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_F3) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Next state and control outputs; fetch states never look at ir_op
  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    alu_op  = ALU_PASS_B;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_F1;
        end
      end
      ST_F1: begin
        ctrl[CTRL_C2] = 1'b1;
        state_d       = ST_F2;
      end
      ST_F2: begin
        ctrl[CTRL_C3] = 1'b1;
        ctrl[CTRL_C1] = 1'b1;
        state_d       = ST_F3;
      end
      ST_F3: begin
        ctrl[CTRL_C4] = 1'b1;
        state_d       = ST_DEC;
      end
      ST_DEC: begin
        state_d = ST_F1;
        case (dec_cls)
          CLS_MEMRD, CLS_STORE, CLS_MPY: begin
            ctrl[CTRL_C0] = 1'b1;
            state_d       = ST_E1;
          end
          CLS_JMP:  ctrl[CTRL_C10] = 1'b1;
          CLS_JMPC: ctrl[CTRL_C10] = ~acc_msb;
          CLS_ALU1: begin
            ctrl[CTRL_C7] = 1'b1;
            alu_op        = dec_alu;
          end
          CLS_CLR:  ctrl[CTRL_C6] = 1'b1;
          CLS_HALT: state_d = ST_HALT;
          default:  state_d = ST_F1;
        endcase
      end
      ST_E1: begin
        state_d = ST_E2;
        if (dec_cls == CLS_STORE) begin
          ctrl[CTRL_C8] = 1'b1;
        end else begin
          ctrl[CTRL_C3] = 1'b1;
        end
      end
      ST_E2: begin
        if (dec_cls == CLS_STORE) begin
          ctrl[CTRL_C9] = 1'b1;
          state_d       = ST_F1;
        end else begin
          ctrl[CTRL_C5] = 1'b1;
          state_d       = ST_E3;
        end
      end
      ST_E3: begin
`ifdef CU_MPY_EN
        // MPY keeps its ALU select while waiting; ACC loads on completion
        if (dec_cls == CLS_MPY) begin
          alu_op = ALU_MPY;
          if (mul_done) begin
            ctrl[CTRL_C7] = 1'b1;
            state_d       = ST_F1;
          end
        end else
`endif
        begin
          ctrl[CTRL_C7] = 1'b1;
          alu_op        = dec_alu;
          state_d       = ST_F1;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  assign halted    = (state_q == ST_HALT);
  assign instr_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_cu_sequencer.sv
// ============================================================================
//  Module    : tb_cu_sequencer
//  Purpose   : Directed vector bench for cu_sequencer. A narrow counter
//              (CNT_W=4) lets the instruction stream wrap instr_cnt.
//  Options   : CU_MPY_EN - expectations for opcode 0x0C follow the macro
//  Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cu_sequencer;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [7:0]       ir_op;
  logic             acc_msb;
  logic             mul_done;
  logic [10:0]      ctrl;
  logic [2:0]       alu_op;
  logic             halted;
  logic [CNT_W-1:0] instr_cnt;

  cu_sequencer #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ir_op     (ir_op),
    .acc_msb   (acc_msb),
    .mul_done  (mul_done),
    .ctrl      (ctrl),
    .alu_op    (alu_op),
    .halted    (halted),
    .instr_cnt (instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             st;
    logic [7:0]       op;
    logic             msb;
    logic             md;
    logic [10:0]      e_ctrl;
    logic [2:0]       e_alu;
    logic             e_halt;
    logic [CNT_W-1:0] e_cnt;
  } vec_t;

  vec_t             tbl[$];
  logic [CNT_W-1:0] ec;
  int               n_vec;
  int               n_miss;

  task automatic push(input logic st, input logic [7:0] op, input logic msb,
                      input logic md, input logic [10:0] c, input logic [2:0] a,
                      input logic h, input logic [CNT_W-1:0] n);
    vec_t v;
    v.st = st; v.op = op; v.msb = msb; v.md = md;
    v.e_ctrl = c; v.e_alu = a; v.e_halt = h; v.e_cnt = n;
    tbl.push_back(v);
  endtask

  // Three fetch cycles; ir_op still shows the previous opcode, acc_msb and
  // mul_done are set and a stray start arrives in F2, none of which matter
  task automatic push_fetch(input logic [7:0] prev_op);
    push(1'b0, prev_op, 1'b1, 1'b1, 11'h004, 3'd0, 1'b0, ec);
    push(1'b1, prev_op, 1'b1, 1'b1, 11'h00A, 3'd0, 1'b0, ec);
    push(1'b0, prev_op, 1'b1, 1'b1, 11'h010, 3'd0, 1'b0, ec);
    ec = ec + 1'b1;
  endtask

  // Drive one cycle's inputs, then compare outputs just after they settle
  task automatic drive_check(input string name, input logic st, input logic [7:0] op,
                             input logic msb, input logic md, input logic [10:0] c,
                             input logic [2:0] a, input logic h,
                             input logic [CNT_W-1:0] n);
    start = st; ir_op = op; acc_msb = msb; mul_done = md;
    #1;
    n_vec++;
    if ({ctrl, alu_op, halted, instr_cnt} !== {c, a, h, n}) begin
      n_miss++;
      $display("FAIL %s: got ctrl=%h alu_op=%0d halted=%b instr_cnt=%0d, want ctrl=%h alu_op=%0d halted=%b instr_cnt=%0d",
               name, ctrl, alu_op, halted, instr_cnt, c, a, h, n);
    end
  endtask

  task automatic step(input string name, input logic st, input logic [7:0] op,
                      input logic msb, input logic md, input logic [10:0] c,
                      input logic [2:0] a, input logic h, input logic [CNT_W-1:0] n);
    drive_check(name, st, op, msb, md, c, a, h, n);
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0; n_miss = 0; ec = '0;
    rst_n = 1'b0; start = 1'b0; ir_op = 8'h00; acc_msb = 1'b0; mul_done = 1'b0;

    // ---------------- vector table ----------------
    push(1'b0, 8'h00, 1'b0, 1'b0, 11'h000, 3'd0, 1'b0, 4'd0);   // idle
    push(1'b1, 8'h00, 1'b0, 1'b0, 11'h000, 3'd0, 1'b0, 4'd0);   // start pulse
    push_fetch(8'h00);                                            // LOAD
    push(0, 8'h01, 0, 0, 11'h001, 3'd0, 0, ec);
    push(0, 8'h01, 0, 0, 11'h008, 3'd0, 0, ec);
    push(0, 8'h01, 0, 0, 11'h020, 3'd0, 0, ec);
    push(0, 8'h01, 0, 0, 11'h080, 3'd0, 0, ec);
    push_fetch(8'h01);                                            // ADD
    push(0, 8'h03, 0, 0, 11'h001, 3'd0, 0, ec);
    push(0, 8'h03, 0, 0, 11'h008, 3'd0, 0, ec);
    push(0, 8'h03, 0, 0, 11'h020, 3'd0, 0, ec);
    push(0, 8'h03, 0, 0, 11'h080, 3'd1, 0, ec);
    push_fetch(8'h03);                                            // STORE
    push(0, 8'h02, 0, 0, 11'h001, 3'd0, 0, ec);
    push(0, 8'h02, 0, 0, 11'h100, 3'd0, 0, ec);
    push(0, 8'h02, 0, 0, 11'h200, 3'd0, 0, ec);
    push_fetch(8'h02);                                            // JMPGEZ taken
    push(0, 8'h05, 0, 0, 11'h400, 3'd0, 0, ec);
    push_fetch(8'h05);                                            // JMPGEZ not taken
    push(0, 8'h05, 1, 0, 11'h000, 3'd0, 0, ec);
    push_fetch(8'h05);                                            // JMP (ignores msb)
    push(0, 8'h06, 1, 0, 11'h400, 3'd0, 0, ec);
    push_fetch(8'h06);                                            // NOT
    push(0, 8'h0A, 0, 0, 11'h080, 3'd5, 0, ec);
    push_fetch(8'h0A);                                            // SHR
    push(0, 8'h0B, 0, 0, 11'h080, 3'd6, 0, ec);
    push_fetch(8'h0B);                                            // CLR
    push(0, 8'h0D, 0, 0, 11'h040, 3'd0, 0, ec);
    push_fetch(8'h0D);                                            // SUB
    push(0, 8'h04, 0, 0, 11'h001, 3'd0, 0, ec);
    push(0, 8'h04, 0, 0, 11'h008, 3'd0, 0, ec);
    push(0, 8'h04, 0, 0, 11'h020, 3'd0, 0, ec);
    push(0, 8'h04, 0, 0, 11'h080, 3'd2, 0, ec);
    push_fetch(8'h04);                                            // AND
    push(0, 8'h08, 0, 0, 11'h001, 3'd0, 0, ec);
    push(0, 8'h08, 0, 0, 11'h008, 3'd0, 0, ec);
    push(0, 8'h08, 0, 0, 11'h020, 3'd0, 0, ec);
    push(0, 8'h08, 0, 0, 11'h080, 3'd3, 0, ec);
    push_fetch(8'h08);                                            // OR
    push(0, 8'h09, 0, 0, 11'h001, 3'd0, 0, ec);
    push(0, 8'h09, 0, 0, 11'h008, 3'd0, 0, ec);
    push(0, 8'h09, 0, 0, 11'h020, 3'd0, 0, ec);
    push(0, 8'h09, 0, 0, 11'h080, 3'd4, 0, ec);
    push_fetch(8'h09);                                            // NOP 0x00
    push(0, 8'h00, 0, 0, 11'h000, 3'd0, 0, ec);
    push_fetch(8'h00);                                            // NOP 0xFF
    push(0, 8'hFF, 0, 0, 11'h000, 3'd0, 0, ec);
    push_fetch(8'hFF);                                            // NOP 0x0E
    push(0, 8'h0E, 0, 0, 11'h000, 3'd0, 0, ec);
    push_fetch(8'h0E);                                            // HALT, counter wraps to 0
    push(0, 8'h07, 0, 0, 11'h000, 3'd0, 0, ec);
    push(0, 8'h07, 0, 0, 11'h000, 3'd0, 1, ec);
    push(1, 8'h07, 0, 0, 11'h000, 3'd0, 1, ec);                  // start ignored

    // ---------------- reset state ----------------
    @(negedge clk);
    @(negedge clk);
    drive_check("reset", 1'b1, 8'h01, 1'b0, 1'b0, 11'h000, 3'd0, 1'b0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("vec[%0d]", i), tbl[i].st, tbl[i].op, tbl[i].msb, tbl[i].md,
           tbl[i].e_ctrl, tbl[i].e_alu, tbl[i].e_halt, tbl[i].e_cnt);
    end

    // ---------------- HALT is terminal until reset ----------------
    for (int i = 0; i < 20; i++) begin
      step("halt_hold", (i == 0), 8'h07, 1'b0, 1'b0, 11'h000, 3'd0, 1'b1, ec);
    end
    #3 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({ctrl, alu_op, halted, instr_cnt} !== {11'h000, 3'd0, 1'b0, 4'd0}) begin
      n_miss++;
      $display("FAIL halt_async_rst: got ctrl=%h alu_op=%0d halted=%b instr_cnt=%0d, want all zero",
               ctrl, alu_op, halted, instr_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- reset in the middle of STORE E2 ----------------
    step("st_idle",  1'b1, 8'h07, 0, 0, 11'h000, 3'd0, 0, 4'd0);
    step("st_f1",    1'b0, 8'h07, 0, 0, 11'h004, 3'd0, 0, 4'd0);
    step("st_f2",    1'b0, 8'h07, 0, 0, 11'h00A, 3'd0, 0, 4'd0);
    step("st_f3",    1'b0, 8'h07, 0, 0, 11'h010, 3'd0, 0, 4'd0);
    step("st_dec",   1'b0, 8'h02, 0, 0, 11'h001, 3'd0, 0, 4'd1);
    step("st_e1",    1'b0, 8'h02, 0, 0, 11'h100, 3'd0, 0, 4'd1);
    drive_check("st_e2", 1'b0, 8'h02, 0, 0, 11'h200, 3'd0, 0, 4'd1);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({ctrl, alu_op, halted, instr_cnt} !== {11'h000, 3'd0, 1'b0, 4'd0}) begin
      n_miss++;
      $display("FAIL e2_async_rst: got ctrl=%h alu_op=%0d halted=%b instr_cnt=%0d, want all zero",
               ctrl, alu_op, halted, instr_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("post_rst_idle", 1'b0, 8'h02, 0, 0, 11'h000, 3'd0, 0, 4'd0);
    end
    step("mpy_start", 1'b1, 8'h02, 0, 0, 11'h000, 3'd0, 0, 4'd0);

    // ---------------- opcode 0x0C (MPY or NOP) ----------------
    step("mpy_f1",  1'b0, 8'h02, 0, 1, 11'h004, 3'd0, 0, 4'd0);
    step("mpy_f2",  1'b0, 8'h02, 0, 1, 11'h00A, 3'd0, 0, 4'd0);
    step("mpy_f3",  1'b0, 8'h02, 0, 1, 11'h010, 3'd0, 0, 4'd0);
`ifdef CU_MPY_EN
    step("mpy_dec", 1'b0, 8'h0C, 0, 1, 11'h001, 3'd0, 0, 4'd1);
    step("mpy_e1",  1'b0, 8'h0C, 0, 1, 11'h008, 3'd0, 0, 4'd1);
    step("mpy_e2",  1'b0, 8'h0C, 0, 1, 11'h020, 3'd0, 0, 4'd1);
    for (int i = 0; i < 5; i++) begin
      step("mpy_e3_wait", 1'b0, 8'h0C, 0, 0, 11'h000, 3'd7, 0, 4'd1);
    end
    step("mpy_e3_done", 1'b0, 8'h0C, 0, 1, 11'h080, 3'd7, 0, 4'd1);
    step("mpy_next_f1", 1'b0, 8'h0C, 0, 0, 11'h004, 3'd0, 0, 4'd1);
`else
    step("mpy_dec",     1'b0, 8'h0C, 0, 1, 11'h000, 3'd0, 0, 4'd1);
    step("mpy_next_f1", 1'b0, 8'h0C, 0, 1, 11'h004, 3'd0, 0, 4'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cu_sequencer.md
# cu_sequencer

Hardwired control unit for the accumulator CPU. It sequences fetch, decode and execute, and drives the datapath control bits C0–C10, including the C4 load strobe of the instruction register. It decodes the 8-bit opcode the instruction register returns from MBR[15:8]. It sits beside the datapath (PC, MAR, MBR, IR, BR, ACC, ALU) and is the sole source of their enables.

## Interface
Parameters:
- CNT_W, 16, width of the retired-instruction counter

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; leaves IDLE
- ir_op  in  8  opcode from instruction register output
- acc_msb  in  1  ACC sign bit
- mul_done  in  1  multiplier completion (only with CU_MPY_EN)
- ctrl  out  11  C0..C10 enables (bit n = Cn)
- alu_op  out  3  ALU function select
- halted  out  1  high in HALT state
- instr_cnt  out  CNT_W  instructions fetched, wraps

## Operation
Control bits:
- C0: MAR<-MBR[7:0]
- C1: PC<-PC+1
- C2: MAR<-PC
- C3: MBR<-M[MAR]
- C4: IR<-MBR[15:8]
- C5: BR<-MBR
- C6: ACC<-0
- C7: ACC<-ALU
- C8: MBR<-ACC
- C9: M[MAR]<-MBR
- C10: PC<-MBR[7:0]

alu_op encoding: 0 PASS_B, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 NOT, 6 SHR, 7 MPY.

State sequence:
- IDLE: ctrl=0. Goes to F1 on start; otherwise stays.
- F1: C2.
- F2: C3 and C1.
- F3: C4. instr_cnt increments.
- DEC: per opcode, below.
- E1, E2, E3: execute states.
- HALT: terminal.

Opcode behaviour:
- LOAD 0x01, ADD 0x03, SUB 0x04, AND 0x08, OR 0x09: DEC C0 -> E1 C3 -> E2 C5 -> E3 C7 with alu_op 0/1/2/3/4 -> F1.
- STORE 0x02: DEC C0 -> E1 C8 -> E2 C9 -> F1.
- JMP 0x06: DEC C10 -> F1.
- JMPGEZ 0x05: DEC C10 only if acc_msb=0 -> F1.
- NOT 0x0A, SHR 0x0B: DEC C7 with alu_op 5/6 -> F1.
- HALT 0x07: DEC ctrl=0 -> HALT. halted=1. Stays until reset; start is ignored.
- CLR 0x0D: DEC C6 -> F1.
- All other opcodes (including 0x00): NOP, DEC -> F1.

General rules:
- ctrl and alu_op are a combinational function of the registered state, ir_op and acc_msb.
- alu_op=0 in every state that does not assert C7.
- Never more than one of C0/C2 in a cycle. Never C10 and C1 in the same cycle.
- ir_op is sampled only in DEC and E-states. In F1–F3 it may still hold the previous opcode and must not affect ctrl.

## Timing
- Reset (any state, any cycle): state=IDLE, ctrl=0, alu_op=0, halted=0, instr_cnt=0. The next cycle after deassert is IDLE.
- Fetch is 3 cycles, decode 1.
- Instruction latency from F1 to the next F1: LOAD-class 7, STORE 6, JMP/JMPGEZ/NOT/SHR/CLR/NOP 4.
- start during a non-IDLE state is ignored.
- instr_cnt wraps from 2^CNT_W-1 to 0. It increments once per F3, including for the HALT instruction.
- acc_msb is sampled only in the DEC cycle of JMPGEZ.

## Configuration
- CU_MPY_EN defined:
  - MPY 0x0C: DEC C0 -> E1 C3 -> E2 C5 -> E3 with alu_op=7, waiting.
  - E3 holds until mul_done=1. In that cycle C7 asserts, then F1.
  - mul_done=1 already on the first E3 cycle gives a 1-cycle E3.
  - mul_done outside E3 is ignored.
- CU_MPY_EN undefined: 0x0C is a NOP, mul_done is unused, and alu_op never equals 7.

## Structure
- Shared package/header cu_defs:
  - opcode constants
  - state encoding: IDLE, F1, F2, F3, DEC, E1, E2, E3, HALT
  - ctrl bit indices C0..C10
  - alu_op codes
- One sub-module, cu_decode: combinational ir_op -> instruction class (MEMRD, STORE, JMP, JMPC, ALU1, CLR, HALT, MPY, NOP) plus its alu_op.

## Test plan
- Reset then start: 1 cycle after start, ctrl=C2 (0x004); next cycle ctrl=0x00A; next 0x010; instr_cnt 0->1.
- LOAD (ir_op=0x01): ctrl sequence from DEC is 0x001, 0x008, 0x020, 0x080 with alu_op=0 in the last cycle, then F1.
- JMPGEZ with acc_msb=0: ctrl=0x400 in DEC. With acc_msb=1: ctrl=0x000 in DEC. Both reach F1 next cycle.
- HALT 0x07: halted=1 from the cycle after DEC. A start pulse and 20 idle cycles leave ctrl=0 and halted=1. Asserting rst_n=0 clears everything immediately.
- Reset asserted mid-E2 of STORE: ctrl drops to 0 asynchronously. After release, the block waits in IDLE for start.
- CU_MPY_EN, ir_op=0x0C, mul_done after 5 cycles in E3: alu_op=7 held throughout E3, C7 only in the mul_done cycle. Without the macro, the same opcode takes 4 cycles as a NOP.
